// File: rtl/pmc_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : pmc_bank_if
// Brief    : Event, configuration, snapshot and read bus for pmc_bank.
// Revision : 1.0 - initial release
// ============================================================================
interface pmc_bank_if #(
  parameter int NUM_CNT = 4,
  parameter int CNT_W   = 32,
  parameter int NUM_EVT = 8,
  parameter int IDX_W   = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1,
  parameter int SEL_W   = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1
);
  logic [NUM_EVT-1:0] evt_in;
  logic               cfg_we;
  logic [IDX_W-1:0]   cfg_idx;
  logic [SEL_W-1:0]   cfg_evt_sel;
  logic               cfg_en;
  logic               cfg_sat;
  logic               cfg_clr;
  logic               freeze;
  logic               snap;
  logic               snap_clr;
  logic               rd_en;
  logic [IDX_W-1:0]   rd_idx;
  logic [CNT_W-1:0]   rd_data;
  logic               rd_ovf;
  logic               rd_valid;

  modport master (
    output evt_in, cfg_we, cfg_idx, cfg_evt_sel, cfg_en, cfg_sat, cfg_clr,
    output freeze, snap, snap_clr, rd_en, rd_idx,
    input  rd_data, rd_ovf, rd_valid
  );

  modport slave (
    input  evt_in, cfg_we, cfg_idx, cfg_evt_sel, cfg_en, cfg_sat, cfg_clr,
    input  freeze, snap, snap_clr, rd_en, rd_idx,
    output rd_data, rd_ovf, rd_valid
  );
endinterface
`default_nettype wire

// File: rtl/pmc_bank.sv
`default_nettype none
// ============================================================================
// Module   : pmc_bank
// Brief    : Bank of configurable performance counters with snapshot shadows.
// Revision : 1.0 - initial release
// ============================================================================
module pmc_bank #(
  parameter int NUM_CNT = 4,
  parameter int CNT_W   = 32,
  parameter int NUM_EVT = 8,
  parameter int IDX_W   = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1,
  parameter int SEL_W   = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1
) (
  input  wire logic clk,
  input  wire logic reset,
  pmc_bank_if.slave bus
);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic [CNT_W-1:0]   r_cnt        [NUM_CNT];
  logic [CNT_W-1:0]   r_shadow     [NUM_CNT];
  logic [SEL_W-1:0]   r_sel        [NUM_CNT];
  logic [NUM_CNT-1:0] r_ovf;
  logic [NUM_CNT-1:0] r_shadow_ovf;
  logic [NUM_CNT-1:0] r_en;
  logic [NUM_CNT-1:0] r_sat;

  logic [NUM_CNT-1:0] w_hit;
  logic [NUM_CNT-1:0] w_clr;
  logic [NUM_CNT-1:0] w_cfg_sel;
  logic               w_snap_clr;
  logic [IDX_W-1:0]   w_cfg_idx;
  logic [IDX_W-1:0]   w_rd_idx;
  logic [CNT_W-1:0]   w_rd_data;
  logic               w_rd_ovf;

  logic [CNT_W-1:0]   r_rd_data;
  logic               r_rd_ovf;
  logic               r_rd_valid;

  assign w_cfg_idx  = bus.cfg_idx;
  assign w_rd_idx   = bus.rd_idx;
  assign w_snap_clr = bus.snap & bus.snap_clr;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_ctl
      logic w_evt;

      // Out-of-range selects (non power-of-two NUM_EVT) never count.
      always_comb begin
        w_evt = 1'b0;
        for (int e = 0; e < NUM_EVT; e++) begin
          if (int'(r_sel[gi]) == e) w_evt = bus.evt_in[e];
        end
      end

      assign w_hit[gi]     = r_en[gi] & ~bus.freeze & w_evt;
      assign w_cfg_sel[gi] = bus.cfg_we & (int'(w_cfg_idx) == gi);
      assign w_clr[gi]     = w_snap_clr | (w_cfg_sel[gi] & bus.cfg_clr);
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        r_cnt[i]    <= '0;
        r_shadow[i] <= '0;
        r_sel[i]    <= SEL_W'(i % NUM_EVT);
      end
      r_ovf        <= '0;
      r_shadow_ovf <= '0;
      r_en         <= '0;
      r_sat        <= '0;
    end else begin
      // Shadows take the pre-edge values, so a same-cycle clear or increment is excluded.
      if (bus.snap) begin
        for (int i = 0; i < NUM_CNT; i++) r_shadow[i] <= r_cnt[i];
        r_shadow_ovf <= r_ovf;
      end
      for (int i = 0; i < NUM_CNT; i++) begin
        if (w_clr[i]) begin
          r_cnt[i] <= '0;
          r_ovf[i] <= 1'b0;
        end else if (w_hit[i]) begin
          if (r_cnt[i] == c_cnt_max) begin
            r_ovf[i] <= 1'b1;
            if (!r_sat[i]) r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end
        end
        if (w_cfg_sel[i]) begin
          r_sel[i] <= bus.cfg_evt_sel;
          r_en[i]  <= bus.cfg_en;
          r_sat[i] <= bus.cfg_sat;
        end
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_ovf  = 1'b0;
    for (int k = 0; k < NUM_CNT; k++) begin
      if (int'(w_rd_idx) == k) begin
        w_rd_data = r_shadow[k];
        w_rd_ovf  = r_shadow_ovf[k];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data  <= '0;
      r_rd_ovf   <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        r_rd_data <= w_rd_data;
        r_rd_ovf  <= w_rd_ovf;
      end
    end
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_ovf   = r_rd_ovf;
  assign bus.rd_valid = r_rd_valid;
endmodule
`default_nettype wire

// File: tb/tb_pmc_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_pmc_bank
// Brief    : Self-checking bench for pmc_bank against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pmc_bank;
  localparam int NUM_CNT = 4;
  localparam int CNT_W   = 8;
  localparam int NUM_EVT = 8;
  localparam int IDX_W   = 3;
  localparam int SEL_W   = 3;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  pmc_bank_if #(.NUM_CNT(NUM_CNT), .CNT_W(CNT_W), .NUM_EVT(NUM_EVT),
                .IDX_W(IDX_W), .SEL_W(SEL_W)) bus ();

  pmc_bank #(.NUM_CNT(NUM_CNT), .CNT_W(CNT_W), .NUM_EVT(NUM_EVT),
             .IDX_W(IDX_W), .SEL_W(SEL_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  int m_cnt [NUM_CNT];
  bit m_ovf [NUM_CNT];
  int m_sel [NUM_CNT];
  bit m_en  [NUM_CNT];
  bit m_sat [NUM_CNT];
  int m_sh  [NUM_CNT];
  bit m_sho [NUM_CNT];
  bit m_valid;
  int m_data;
  bit m_rovf;

  typedef struct {
    logic [7:0] evt;
    bit         frz;
    bit         snp;
    bit         sclr;
    bit         ren;
    logic [2:0] ridx;
    bit         ev;
    int         ed;
    bit         eo;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CNT; i++) begin
      m_cnt[i] = 0; m_ovf[i] = 0; m_sel[i] = i % NUM_EVT;
      m_en[i] = 0; m_sat[i] = 0; m_sh[i] = 0; m_sho[i] = 0;
    end
    m_valid = 0; m_data = 0; m_rovf = 0;
  endtask

  task automatic model_step();
    int ci;
    m_valid = bus.rd_en;
    if (bus.rd_en) begin
      if (int'(bus.rd_idx) < NUM_CNT) begin
        m_data = m_sh[bus.rd_idx];
        m_rovf = m_sho[bus.rd_idx];
      end else begin
        m_data = 0;
        m_rovf = 0;
      end
    end
    if (bus.snap) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        m_sh[i]  = m_cnt[i];
        m_sho[i] = m_ovf[i];
      end
    end
    ci = int'(bus.cfg_idx);
    for (int i = 0; i < NUM_CNT; i++) begin
      if ((bus.snap && bus.snap_clr) || (bus.cfg_we && bus.cfg_clr && ci == i)) begin
        m_cnt[i] = 0;
        m_ovf[i] = 0;
      end else if (m_en[i] && !bus.freeze && bus.evt_in[m_sel[i]]) begin
        if (m_cnt[i] == CMAX) begin
          m_ovf[i] = 1;
          if (!m_sat[i]) m_cnt[i] = 0;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
    if (bus.cfg_we && ci < NUM_CNT) begin
      m_sel[ci] = int'(bus.cfg_evt_sel);
      m_en[ci]  = bus.cfg_en;
      m_sat[ci] = bus.cfg_sat;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("model_valid", int'(bus.rd_valid), int'(m_valid));
    chk("model_data",  int'(bus.rd_data),  m_data);
    chk("model_ovf",   int'(bus.rd_ovf),   int'(m_rovf));
  endtask

  task automatic idle();
    bus.evt_in = '0; bus.cfg_we = 0; bus.cfg_idx = '0; bus.cfg_evt_sel = '0;
    bus.cfg_en = 0; bus.cfg_sat = 0; bus.cfg_clr = 0; bus.freeze = 0;
    bus.snap = 0; bus.snap_clr = 0; bus.rd_en = 0; bus.rd_idx = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    @(posedge clk);
    #3;
    reset = 1'b0;
    model_reset();
    chk("rst_valid", int'(bus.rd_valid), 0);
    chk("rst_data",  int'(bus.rd_data),  0);
    chk("rst_ovf",   int'(bus.rd_ovf),   0);
  endtask

  task automatic cfg_write(input int idx, input int sel, input bit en, input bit sat, input bit clr);
    bus.cfg_we = 1; bus.cfg_idx = 3'(idx); bus.cfg_evt_sel = 3'(sel);
    bus.cfg_en = en; bus.cfg_sat = sat; bus.cfg_clr = clr;
    tick();
    bus.cfg_we = 0; bus.cfg_clr = 0;
  endtask

  task automatic events(input logic [7:0] evt, input int n);
    bus.evt_in = evt;
    for (int k = 0; k < n; k++) tick();
    bus.evt_in = '0;
  endtask

  task automatic do_snap(input bit clr);
    bus.snap = 1; bus.snap_clr = clr;
    tick();
    bus.snap = 0; bus.snap_clr = 0;
  endtask

  task automatic rd(input string name, input int idx, input int exp_d, input int exp_o);
    bus.rd_en = 1; bus.rd_idx = 3'(idx);
    tick();
    bus.rd_en = 0;
    chk({name, "_valid"}, int'(bus.rd_valid), 1);
    chk({name, "_data"},  int'(bus.rd_data),  exp_d);
    chk({name, "_ovf"},   int'(bus.rd_ovf),   exp_o);
  endtask

  initial begin
    idle();
    model_reset();
    #12;
    reset = 1'b0;
    chk("rst_valid", int'(bus.rd_valid), 0);
    chk("rst_data",  int'(bus.rd_data),  0);
    chk("rst_ovf",   int'(bus.rd_ovf),   0);

    // Ten cycle events on counter 0, then snapshot and read back.
    cfg_write(0, 0, 1, 0, 0);
    events(8'h01, 10);
    do_snap(0);
    rd("basic", 0, 10, 0);
    tick();
    chk("hold_valid", int'(bus.rd_valid), 0);
    chk("hold_data",  int'(bus.rd_data),  10);

    // Freeze masking on counter 1; counter 2 stays disabled.
    cfg_write(1, 1, 1, 0, 0);
    tbl[0]  = '{8'h02, 1, 0, 0, 0, 3'd0, 0, 10, 0};
    tbl[1]  = '{8'h00, 0, 0, 0, 0, 3'd0, 0, 10, 0};
    tbl[2]  = '{8'h02, 1, 0, 0, 0, 3'd0, 0, 10, 0};
    tbl[3]  = '{8'h00, 0, 0, 0, 0, 3'd0, 0, 10, 0};
    tbl[4]  = '{8'h02, 0, 0, 0, 0, 3'd0, 0, 10, 0};
    tbl[5]  = '{8'h00, 0, 0, 0, 0, 3'd0, 0, 10, 0};
    tbl[6]  = '{8'h00, 0, 1, 0, 0, 3'd0, 0, 10, 0};
    tbl[7]  = '{8'h00, 0, 0, 0, 1, 3'd1, 1, 1,  0};
    tbl[8]  = '{8'h00, 0, 0, 0, 1, 3'd2, 1, 0,  0};
    tbl[9]  = '{8'h00, 0, 0, 0, 1, 3'd0, 1, 10, 0};
    tbl[10] = '{8'h00, 0, 0, 0, 1, 3'd5, 1, 0,  0};
    tbl[11] = '{8'h00, 0, 0, 0, 0, 3'd0, 0, 0,  0};
    for (int v = 0; v < 12; v++) begin
      bus.evt_in = tbl[v].evt; bus.freeze = tbl[v].frz; bus.snap = tbl[v].snp;
      bus.snap_clr = tbl[v].sclr; bus.rd_en = tbl[v].ren; bus.rd_idx = tbl[v].ridx;
      tick();
      chk($sformatf("tbl%0d_valid", v), int'(bus.rd_valid), int'(tbl[v].ev));
      chk($sformatf("tbl%0d_data", v),  int'(bus.rd_data),  tbl[v].ed);
      chk($sformatf("tbl%0d_ovf", v),   int'(bus.rd_ovf),   int'(tbl[v].eo));
    end
    idle();

    // Atomic snapshot-and-clear drops the same-cycle event.
    cfg_write(0, 0, 1, 0, 1);
    events(8'h01, 5);
    bus.evt_in = 8'h01;
    do_snap(1);
    bus.evt_in = '0;
    rd("snapclr", 0, 5, 0);
    events(8'h01, 4);
    do_snap(0);
    rd("after_clr", 0, 4, 0);

    // Event in a config-write cycle counts under the old select.
    cfg_write(3, 3, 1, 0, 0);
    bus.evt_in = 8'h08;
    cfg_write(3, 2, 1, 0, 0);
    events(8'h08, 3);
    cfg_write(7, 0, 0, 1, 1);
    events(8'h04, 1);
    do_snap(0);
    rd("resel", 3, 2, 0);
    rd("oob", 5, 0, 0);

    // Wrap versus saturate past all-ones.
    do_reset();
    cfg_write(0, 0, 1, 0, 0);
    cfg_write(1, 0, 1, 1, 0);
    events(8'h01, 258);
    do_snap(0);
    rd("wrap", 0, 2, 1);
    rd("sat", 1, 255, 1);

    // Asynchronous reset between edges.
    do_reset();
    cfg_write(0, 0, 1, 0, 0);
    events(8'h01, 37);
    do_snap(0);
    rd("pre_rst", 0, 37, 0);
    bus.rd_en = 1; bus.evt_in = 8'h01;
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid", int'(bus.rd_valid), 0);
    chk("async_data",  int'(bus.rd_data),  0);
    chk("async_ovf",   int'(bus.rd_ovf),   0);
    model_reset();
    idle();
    #2;
    reset = 1'b0;
    events(8'h01, 5);
    do_snap(0);
    rd("post_rst", 0, 0, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bus.evt_in      = 8'($urandom);
      bus.freeze      = ($urandom_range(0, 7) == 0);
      bus.snap        = ($urandom_range(0, 9) == 0);
      bus.snap_clr    = ($urandom_range(0, 5) == 0);
      bus.cfg_we      = ($urandom_range(0, 7) == 0);
      bus.cfg_idx     = 3'($urandom_range(0, 7));
      bus.cfg_evt_sel = 3'($urandom_range(0, 7));
      bus.cfg_en      = ($urandom_range(0, 3) != 0);
      bus.cfg_sat     = 1'($urandom_range(0, 1));
      bus.cfg_clr     = ($urandom_range(0, 5) == 0);
      bus.rd_en       = 1'($urandom_range(0, 1));
      bus.rd_idx      = 3'($urandom_range(0, 7));
      tick();
    end
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pmc_bank.md
Name: pmc_bank

Overview:
Parametrised bank of performance-monitoring counters for the pipelined core, successor to the fixed four-counter unit. Each counter is runtime-configured to count one of NUM_EVT single-bit event strobes from the pipeline (cycle, stall, arith op, mem access, etc.), in wrap or saturate mode. Adds global freeze, atomic snapshot-and-clear, sticky overflow flags and a registered read port for the debug/CSR path.

Parameters:
NUM_CNT, 4, number of counters
CNT_W, 32, counter width in bits
NUM_EVT, 8, number of event inputs; integrator wiring: evt_in[0]=cycle, [1]=stall, [2]=arith, [3]=mem access, [7:4] spare
IDX_W, $clog2(NUM_CNT) (min 1), counter index width
SEL_W, $clog2(NUM_EVT) (min 1), event select width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
evt_in  in  NUM_EVT  event strobes, one count per cycle high
cfg_we  in  1  config write strobe
cfg_idx  in  IDX_W  counter to configure
cfg_evt_sel  in  SEL_W  event source for that counter
cfg_en  in  1  counter enable
cfg_sat  in  1  1=saturate, 0=wrap
cfg_clr  in  1  clear that counter and its ovf flag on write
freeze  in  1  level; while high no counter increments
snap  in  1  pulse; copy all counters to shadow regs
snap_clr  in  1  with snap: also clear all live counters and ovf flags
rd_en  in  1  read request
rd_idx  in  IDX_W  shadow register to read
rd_data  out  CNT_W  shadow value
rd_ovf  out  1  overflow flag captured with that shadow
rd_valid  out  1  one-cycle pulse, rd_data/rd_ovf valid

Behaviour:
- Reset (async, any time incl. mid-count): counters, shadows, ovf, shadow-ovf = 0; en=0, sat=0, evt_sel[i]=i mod NUM_EVT; rd_data=0, rd_ovf=0, rd_valid=0.
- Increment: counter i increments by 1 at rising edge when en[i]=1, freeze=0, evt_in[evt_sel[i]]=1. Max +1 per cycle.
- Wrap mode: at all-ones, next increment -> 0, ovf[i] set (sticky).
- Saturate mode: at all-ones, holds all-ones; ovf[i] set on first blocked increment, sticky.
- ovf cleared only by reset, cfg_clr on that counter, or snap with snap_clr.
- Config write: on cfg_we edge, evt_sel/en/sat of counter cfg_idx updated; applies from next cycle. Event in write cycle is counted under old config. cfg_clr=1: counter and ovf -> 0; clear beats same-cycle increment. cfg_idx >= NUM_CNT: write ignored.
- Snapshot: on snap edge, shadow[i] <= counter[i], shadow_ovf[i] <= ovf[i] for all i, using pre-edge values (this cycle's increment excluded). snap_clr=1 also clears all counters and ovf on the same edge; the event in that cycle is lost. Snapshot-and-clear is atomic. snap_clr without snap: ignored.
- Simultaneous cfg_we+cfg_clr and snap: shadow gets pre-clear value, counter cleared.
- freeze does not block config writes, clears or snapshots.
- Read: rd_en at edge N -> rd_data, rd_ovf, rd_valid=1 after edge N (1-cycle latency). Reads shadows only; never live counters. Back-to-back reads allowed, one per cycle. Snap and read in the same cycle return the old shadow. rd_idx >= NUM_CNT -> rd_data=0, rd_ovf=0, rd_valid=1. rd_data/rd_ovf hold their last value when rd_valid=0.

Test Plan:
- Reset then config ctr0 sel=0 en=1; hold evt_in[0]=1 for 10 cycles; snap; read idx0 -> rd_data=10, rd_ovf=0, rd_valid one cycle after rd_en.
- ctr1 sel=1, evt_in[1] pulsed 3 of 6 cycles, freeze high for 2 of those pulses -> shadow1=1; ctr2 en=0 -> 0.
- CNT_W=8, ctr0 wrap, 258 events -> value 2, ovf=1; ctr1 saturate, 258 events -> 255, ovf=1.
- Snap+snap_clr with ctr0=5 and evt high that cycle -> read 5; next snap after 4 events -> 4, ovf=0.
- cfg_we changing ctr3 sel 3->2 with evt_in[3]=1 and evt_in[2]=0 that cycle -> that event counted, later evt_in[3] ignored; cfg_idx=7 with NUM_CNT=4 -> no change; rd_idx=5 -> rd_data=0.
- Assert reset mid-count (ctr0=37) asynchronously between edges -> all outputs 0 immediately; en=0 so no counting after release until reconfigured.
